ddram_responder: RTL and testbench
==================================

Name: ddram_responder

Overview:
- Responder (memory side) of the DDRAM burst interface that the core's DDRAM clients drive.
- Backs the interface with a 64-bit-wide on-chip array and accepts single and burst reads and writes with byte enables.
- Returns read data after a configurable latency and can inject pseudo-random BUSY/data stalls.
- Used as the DDR3 stand-in for bench and on-board loopback testing of the DDRAM clients.

Parameters:
ADDR_BITS, 10, log2 of array depth in 64-bit words; word index = DDRAM_ADDR[ADDR_BITS-1:0], upper bits ignored
READ_LATENCY, 4, cycles from read accept to first DOUT_READY (legal range 1..15)
STALL_EN, 0, 1 = enable LFSR-driven BUSY insertion and read-beat gaps
STALL_SEED, 16'hACE1, LFSR seed loaded on reset (nonzero)

Ports:
DDRAM_CLK  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
DDRAM_BUSY  out  1  responder not accepting; command/beat ignored while high
DDRAM_BURSTCNT  in  8  beats in burst, sampled on first accepted beat
DDRAM_ADDR  in  29  64-bit word address, sampled on first accepted beat
DDRAM_DOUT  out  64  read data
DDRAM_DOUT_READY  out  1  DOUT valid this cycle
DDRAM_RD  in  1  read command
DDRAM_DIN  in  64  write data
DDRAM_BE  in  8  byte enables, bit n covers DIN[8n+7:8n]
DDRAM_WE  in  1  write beat
proto_err  out  1  sticky protocol-violation flag
rd_cmds  out  16  accepted read commands, wraps
wr_beats  out  16  accepted write beats, wraps

Behaviour:
- Accept: edge where BUSY=0 and (RD or WE)=1.
- Reset:
  - While reset is high: BUSY=1, DOUT=0, DOUT_READY=0, proto_err=0, counters=0, state=IDLE, LFSR=STALL_SEED.
  - BUSY is low in the first cycle after reset unless a stall is drawn.
  - Array contents are not cleared.
- States: IDLE, WBURST, RWAIT, RDATA.
- IDLE:
  - Accepted WE: writes DIN to addr under BE on the same edge and latches addr+1 and BURSTCNT-1 as the remaining count. Goes to WBURST if the remaining count is >0, else stays in IDLE.
  - Accepted RD: latches addr and BURSTCNT, loads the latency counter with READ_LATENCY-1, goes to RWAIT.
  - BURSTCNT=0 on accept: command dropped, proto_err set, stay in IDLE.
  - RD and WE both high: treated as a write, proto_err set.
- WBURST:
  - Each accepted WE beat writes at the current addr, then addr increments and the remaining count decrements.
  - Returns to IDLE after the last beat.
  - RD=1 while in WBURST sets proto_err and is ignored.
- RWAIT: BUSY held 1; latency counter decrements; goes to RDATA when the counter reaches 0.
- RDATA:
  - BUSY held 1.
  - Each non-stalled cycle: DOUT = mem[addr], DOUT_READY=1, addr increments, count decrements.
  - After the final beat: IDLE, and BUSY is released on the following cycle.
  - RD or WE asserted while BUSY=1 has no effect and is not an error.
- Timing:
  - Read-after-write visibility: a write accepted on edge N is returned by any read accepted on edge ≥N+1.
  - Read latency without stalls: first DOUT_READY exactly READ_LATENCY cycles after the accept edge. Beats are back-to-back.
- Address arithmetic: modulo 2^ADDR_BITS; bursts wrap silently, which is not an error.
- Stalls (STALL_EN=1): 16-bit Galois LFSR (taps 16,14,13,11) advances every cycle.
  - In IDLE/WBURST, LFSR[1:0]==0 forces BUSY=1 for that cycle.
  - In RDATA, LFSR[1:0]==0 suppresses that beat: DOUT_READY=0 and addr/count hold.
  - With STALL_EN=0 the LFSR is unused and BUSY only follows the state.
- Outputs:
  - DOUT holds its last value when DOUT_READY=0.
  - rd_cmds increments per accepted RD; wr_beats increments per accepted write beat.
- Reset mid-burst: burst aborted, no further beats; any partial write stays in the array.

Decomposition:
- Package ddram_pkg: DDRAM_ADDR_W=29, DDRAM_DATA_W=64, DDRAM_BE_W=8, DDRAM_BURST_W=8, and the state enum (IDLE/WBURST/RWAIT/RDATA).
- Sub-module ddram_lfsr: 16-bit LFSR with seed, enable, and a 2-bit stall-tap output.
- Array inferred inside ddram_responder; byte-lane write enables are generated in a loop.

Test Plan:
- Single write addr=0x3000005, DIN=0x1122334455667788, BE=8'h0C, then BURSTCNT=1 read of the same addr -> DOUT_READY 4 cycles after the read accept; DOUT bytes 2..3 = 0x5566, other bytes = prior contents; wr_beats=1, rd_cmds=1.
- Write burst BURSTCNT=4 at word 0x3FE (ADDR_BITS=10), data k+1, BE=FF, then 4-beat read at 0x3FE -> four consecutive beats 1,2,3,4; words 0x3FE,0x3FF,0x000,0x001 written (wrap); proto_err=0.
- BURSTCNT=2 read, the DDRAM client's 128-bit line-fill pattern -> BUSY high from the accept+1 edge until the cycle after the 2nd beat; exactly 2 DOUT_READY pulses; RD pulses during BUSY are ignored.
- RD and WE both high in IDLE, and separately BURSTCNT=0 -> write performed (first case) or dropped (second case), proto_err=1 and stays 1 until reset.
- STALL_EN=1 with the default seed, 200 random single writes/reads against a scoreboard -> every read matches and the beat count equals BURSTCNT; at least one BUSY stall and one beat gap are observed.
- Reset asserted during the 2nd beat of a 4-beat read -> DOUT_READY=0 and BUSY=1 next cycle; after release, state IDLE, counters 0, earlier writes still readable.

Source files
------------

// File: rtl/ddram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddram_pkg
// Description : Shared widths and responder state encoding for the DDRAM port.
// Revision    : 1.0  initial release
// ============================================================================
package ddram_pkg;

    localparam int DDRAM_ADDR_W  = 29;
    localparam int DDRAM_DATA_W  = 64;
    localparam int DDRAM_BE_W    = 8;
    localparam int DDRAM_BURST_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_WBURST = 2'd1;
    localparam state_t ST_RWAIT  = 2'd2;
    localparam state_t ST_RDATA  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/ddram_if.sv
`default_nettype none
// ============================================================================
// Module      : ddram_if
// Description : DDRAM burst bus; master = client, slave = memory responder.
// Revision    : 1.0  initial release
// ============================================================================
interface ddram_if;

    logic                                DDRAM_BUSY;
    logic [ddram_pkg::DDRAM_BURST_W-1:0] DDRAM_BURSTCNT;
    logic [ddram_pkg::DDRAM_ADDR_W-1:0]  DDRAM_ADDR;
    logic [ddram_pkg::DDRAM_DATA_W-1:0]  DDRAM_DOUT;
    logic                                DDRAM_DOUT_READY;
    logic                                DDRAM_RD;
    logic [ddram_pkg::DDRAM_DATA_W-1:0]  DDRAM_DIN;
    logic [ddram_pkg::DDRAM_BE_W-1:0]    DDRAM_BE;
    logic                                DDRAM_WE;

    modport master (
        input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        output DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
    );

    modport slave (
        input  DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE,
        output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY
    );

endinterface
`default_nettype wire

// File: rtl/ddram_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : ddram_lfsr
// Description : 16-bit Galois LFSR (taps 16,14,13,11) exposing a 2-bit stall tap.
// Revision    : 1.0  initial release
// ============================================================================
module ddram_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_en,
    output logic      [1:0] o_tap
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (i_en) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign o_tap = lfsr_q[1:0];

endmodule
`default_nettype wire

// File: rtl/ddram_responder.sv
`default_nettype none
// ============================================================================
// Module      : ddram_responder
// Description : On-chip 64-bit memory answering DDRAM burst reads/writes.
// Revision    : 1.0  initial release
// ============================================================================
module ddram_responder
    import ddram_pkg::*;
#(
    parameter int          ADDR_BITS    = 10,
    parameter int          READ_LATENCY = 4,
    parameter int          STALL_EN     = 0,
    parameter logic [15:0] STALL_SEED   = 16'hACE1
) (
    input  wire logic  DDRAM_CLK,
    input  wire logic  reset,
    ddram_if.slave     bus,
    output logic       proto_err,
    output logic [15:0] rd_cmds,
    output logic [15:0] wr_beats
);

    localparam int       DEPTH    = 1 << ADDR_BITS;
    localparam bit       STALL_ON = (STALL_EN != 0);
    localparam logic [3:0] LAT_LOAD = 4'(READ_LATENCY - 1);

    state_t                  state_q, state_d;
    logic [ADDR_BITS-1:0]    addr_q, addr_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [3:0]              lat_q, lat_d;
    logic                    busy_q, busy_d;
    logic [DDRAM_DATA_W-1:0] dout_q, dout_d;
    logic                    ready_q, ready_d;
    logic                    err_q, err_d;
    logic [15:0]             rd_cmds_q, rd_cmds_d;
    logic [15:0]             wr_beats_q, wr_beats_d;

    logic [1:0]              w_tap;
    logic                    w_stall;
    logic                    w_busy;
    logic                    w_rd;
    logic                    w_we;
    logic                    w_wr_fire;
    logic [ADDR_BITS-1:0]    w_waddr;
    logic [DDRAM_BE_W-1:0][7:0] w_rd_bytes;
    logic                    w_unused_addr;

    assign w_unused_addr = &{1'b0, bus.DDRAM_ADDR[DDRAM_ADDR_W-1:ADDR_BITS]};

    ddram_lfsr #(
        .SEED (STALL_SEED)
    ) u_lfsr (
        .clk   (DDRAM_CLK),
        .rst   (reset),
        .i_en  (STALL_ON),
        .o_tap (w_tap)
    );

    assign w_stall = STALL_ON && (w_tap == 2'b00);
    // Stall-driven BUSY only applies where commands could otherwise be taken.
    assign w_busy  = busy_q | (w_stall && (state_q == ST_IDLE || state_q == ST_WBURST));
    assign w_rd    = bus.DDRAM_RD & ~w_busy;
    assign w_we    = bus.DDRAM_WE & ~w_busy;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        dout_d     = dout_q;
        ready_d    = 1'b0;
        err_d      = err_q;
        rd_cmds_d  = rd_cmds_q;
        wr_beats_d = wr_beats_q;
        w_wr_fire  = 1'b0;
        w_waddr    = addr_q;

        case (state_q)
            ST_IDLE: begin
                w_waddr = bus.DDRAM_ADDR[ADDR_BITS-1:0];
                if (w_we || w_rd) begin
                    if (bus.DDRAM_BURSTCNT == 8'd0) begin
                        err_d = 1'b1;
                    end else if (w_we) begin
                        // A simultaneous RD loses to the write and is flagged.
                        err_d      = err_q | w_rd;
                        w_wr_fire  = 1'b1;
                        wr_beats_d = wr_beats_q + 16'd1;
                        addr_d     = w_waddr + ADDR_BITS'(1);
                        cnt_d      = bus.DDRAM_BURSTCNT - 8'd1;
                        if (cnt_d != 8'd0) begin
                            state_d = ST_WBURST;
                        end
                    end else begin
                        rd_cmds_d = rd_cmds_q + 16'd1;
                        addr_d    = w_waddr;
                        cnt_d     = bus.DDRAM_BURSTCNT;
                        lat_d     = LAT_LOAD;
                        state_d   = (READ_LATENCY <= 1) ? ST_RDATA : ST_RWAIT;
                    end
                end
            end
            ST_WBURST: begin
                if (w_rd) begin
                    err_d = 1'b1;
                end
                if (w_we) begin
                    w_wr_fire  = 1'b1;
                    wr_beats_d = wr_beats_q + 16'd1;
                    addr_d     = addr_q + ADDR_BITS'(1);
                    cnt_d      = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RWAIT: begin
                lat_d = lat_q - 4'd1;
                if (lat_q <= 4'd1) begin
                    state_d = ST_RDATA;
                end
            end
            default: begin
                if (!w_stall) begin
                    dout_d  = {w_rd_bytes};
                    ready_d = 1'b1;
                    addr_d  = addr_q + ADDR_BITS'(1);
                    cnt_d   = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase

        // BUSY covers the whole read plus the cycle carrying the last beat.
        busy_d = (state_d == ST_RWAIT) || (state_d == ST_RDATA) || (state_q == ST_RDATA);
    end

    always_ff @(posedge DDRAM_CLK) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cnt_q      <= 8'd0;
            lat_q      <= 4'd0;
            busy_q     <= 1'b1;
            dout_q     <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            rd_cmds_q  <= 16'd0;
            wr_beats_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            lat_q      <= lat_d;
            busy_q     <= busy_d;
            dout_q     <= dout_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            rd_cmds_q  <= rd_cmds_d;
            wr_beats_q <= wr_beats_d;
        end
    end

    for (genvar g = 0; g < DDRAM_BE_W; g++) begin : g_lane
        logic [7:0] mem [DEPTH];

        always_ff @(posedge DDRAM_CLK) begin
            if (w_wr_fire && bus.DDRAM_BE[g]) begin
                mem[w_waddr] <= bus.DDRAM_DIN[8*g +: 8];
            end
        end

        assign w_rd_bytes[g] = mem[addr_q];
    end

    assign bus.DDRAM_BUSY       = w_busy;
    assign bus.DDRAM_DOUT       = dout_q;
    assign bus.DDRAM_DOUT_READY = ready_q;
    assign proto_err            = err_q;
    assign rd_cmds              = rd_cmds_q;
    assign wr_beats             = wr_beats_q;

endmodule
`default_nettype wire

// File: tb/tb_ddram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddram_responder
// Description : Directed bench for ddram_responder, plain and stalling instances.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ddram_responder;
    import ddram_pkg::*;

    localparam int L = 4;
    localparam int W = 24;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ddram_if bus();
    ddram_if bus_s();

    logic        sel;
    logic        rd, we;
    logic [28:0] addr;
    logic [7:0]  bcnt, be;
    logic [63:0] din;

    assign bus.DDRAM_RD         = rd & ~sel;
    assign bus.DDRAM_WE         = we & ~sel;
    assign bus.DDRAM_ADDR       = addr;
    assign bus.DDRAM_BURSTCNT   = bcnt;
    assign bus.DDRAM_BE         = be;
    assign bus.DDRAM_DIN        = din;
    assign bus_s.DDRAM_RD       = rd & sel;
    assign bus_s.DDRAM_WE       = we & sel;
    assign bus_s.DDRAM_ADDR     = addr;
    assign bus_s.DDRAM_BURSTCNT = bcnt;
    assign bus_s.DDRAM_BE       = be;
    assign bus_s.DDRAM_DIN      = din;

    logic        perr0, perr1;
    logic [15:0] rdc0, rdc1, wrb0, wrb1;

    ddram_responder #(.ADDR_BITS(10), .READ_LATENCY(L), .STALL_EN(0), .STALL_SEED(16'hACE1)) dut (
        .DDRAM_CLK(clk), .reset(reset), .bus(bus),
        .proto_err(perr0), .rd_cmds(rdc0), .wr_beats(wrb0)
    );

    ddram_responder #(.ADDR_BITS(10), .READ_LATENCY(L), .STALL_EN(1), .STALL_SEED(16'hACE1)) dut_s (
        .DDRAM_CLK(clk), .reset(reset), .bus(bus_s),
        .proto_err(perr1), .rd_cmds(rdc1), .wr_beats(wrb1)
    );

    logic        busy_o, ready_o, perr_o;
    logic [63:0] dout_o;
    logic [15:0] rdc_o, wrb_o;
    assign busy_o  = sel ? bus_s.DDRAM_BUSY       : bus.DDRAM_BUSY;
    assign ready_o = sel ? bus_s.DDRAM_DOUT_READY : bus.DDRAM_DOUT_READY;
    assign dout_o  = sel ? bus_s.DDRAM_DOUT       : bus.DDRAM_DOUT;
    assign perr_o  = sel ? perr1 : perr0;
    assign rdc_o   = sel ? rdc1  : rdc0;
    assign wrb_o   = sel ? wrb1  : wrb0;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] rbeat[$];
    int          rlat;
    int          rlast;
    logic [7:0]  bsy_vec, rdy_vec;
    logic        stall_seen = 1'b0;
    logic        gap_seen = 1'b0;
    logic [63:0] sb [16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Starts and ends on a falling edge; beat k carries base+k.
    task automatic do_write(input logic [28:0] a, input int n, input logic [63:0] base,
                            input logic [7:0] b, input logic also_rd);
        int   k;
        int   cyc;
        logic acc;
        k = 0;
        cyc = 0;
        addr = a; bcnt = 8'(n); be = b; we = 1'b1; rd = also_rd;
        while (k < n && cyc < 100) begin
            din = base + 64'(k);
            acc = !busy_o;
            @(negedge clk);
            if (acc) k++;
            else if (sel) stall_seen = 1'b1;
            cyc++;
        end
        we = 1'b0; rd = 1'b0;
        chk("wr_beats_taken", 64'(k), 64'(n));
    endtask

    // Captures a fixed window of W falling edges after the read accept edge.
    task automatic do_read(input logic [28:0] a, input int n, input logic pulse);
        int   cyc;
        logic acc;
        rbeat.delete();
        rlat = -1; rlast = -1; bsy_vec = '0; rdy_vec = '0;
        addr = a; bcnt = 8'(n); rd = 1'b1; cyc = 0; acc = 1'b0;
        while (!acc && cyc < 100) begin
            acc = !busy_o;
            if (!acc && sel) stall_seen = 1'b1;
            @(negedge clk);
            cyc++;
        end
        rd = 1'b0;
        chk("rd_accept", 64'(acc), 64'd1);
        for (int j = 0; j < W; j++) begin
            if (j < 8) begin
                bsy_vec[j] = busy_o;
                rdy_vec[j] = ready_o;
            end
            if (ready_o) begin
                if (rlat < 0) rlat = j;
                rlast = j;
                rbeat.push_back(dout_o);
            end
            rd = pulse && (j < 3);
            addr = 29'h0000123;
            @(negedge clk);
        end
        rd = 1'b0;
        if (sel && rlat >= 0 && (rlat > L || (rlast - rlat + 1) > rbeat.size())) gap_seen = 1'b1;
    endtask

    initial begin
        logic [63:0] v;
        logic [28:0] a;
        logic [7:0]  b;
        int          n;
        int          seen;

        sel = 1'b0; rd = 1'b0; we = 1'b0; addr = '0; bcnt = '0; be = '0; din = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy_o), 64'd1);
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_dout", dout_o, 64'd0);
        chk("rst_perr", 64'(perr_o), 64'd0);
        chk("rst_rdc", 64'(rdc_o), 64'd0);
        chk("rst_wrb", 64'(wrb_o), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("busy_after_rst", 64'(busy_o), 64'd0);

        // Partial write over a known word, then read back
        do_write(29'h3000005, 1, 64'hA0A1A2A3A4A5A6A7, 8'hFF, 1'b0);
        do_write(29'h3000005, 1, 64'h1122334455667788, 8'h0C, 1'b0);
        do_read(29'h3000005, 1, 1'b0);
        chk("be_nbeats", 64'(rbeat.size()), 64'd1);
        if (rbeat.size() >= 1) chk("be_data", rbeat[0], 64'hA0A1A2A35566A6A7);
        chk("be_latency", 64'(rlat), 64'(L));
        chk("be_wrb", 64'(wrb_o), 64'd2);
        chk("be_rdc", 64'(rdc_o), 64'd1);

        // Wrapping write burst, full read back, then a two-beat line fill
        do_write(29'h00003FE, 4, 64'd1, 8'hFF, 1'b0);
        do_read(29'h00003FE, 4, 1'b0);
        chk("wrap_nbeats", 64'(rbeat.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < rbeat.size()) chk("wrap_data", rbeat[k], 64'(k + 1));
        end
        chk("wrap_latency", 64'(rlat), 64'(L));
        do_read(29'h0000000, 2, 1'b1);
        chk("fill_nbeats", 64'(rbeat.size()), 64'd2);
        if (rbeat.size() == 2) begin
            chk("fill_beat0", rbeat[0], 64'd3);
            chk("fill_beat1", rbeat[1], 64'd4);
        end
        chk("fill_busy_trace", 64'(bsy_vec), 64'h3F);
        chk("fill_ready_trace", 64'(rdy_vec), 64'h30);
        chk("fill_rdc", 64'(rdc_o), 64'd3);
        chk("fill_wrb", 64'(wrb_o), 64'd6);
        chk("fill_perr", 64'(perr_o), 64'd0);

        // RD and WE together: write wins, error flagged
        do_write(29'h0000009, 1, 64'h0909090909090909, 8'hFF, 1'b0);
        do_write(29'h0000008, 1, 64'hFEEDFACECAFEBEEF, 8'hFF, 1'b1);
        chk("rdwe_perr", 64'(perr_o), 64'd1);
        chk("rdwe_wrb", 64'(wrb_o), 64'd8);
        chk("rdwe_rdc", 64'(rdc_o), 64'd3);
        do_read(29'h0000008, 1, 1'b0);
        if (rbeat.size() >= 1) chk("rdwe_data", rbeat[0], 64'hFEEDFACECAFEBEEF);
        chk("rdwe_perr_sticky", 64'(perr_o), 64'd1);

        // Reset during the second beat of a four-beat read
        addr = 29'h00003FE; bcnt = 8'd4; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_beat2_ready", 64'(ready_o), 64'd1);
        chk("mid_beat2_data", dout_o, 64'd2);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 64'(ready_o), 64'd0);
        chk("mid_rst_busy", 64'(busy_o), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_post_busy", 64'(busy_o), 64'd0);
        chk("mid_post_perr", 64'(perr_o), 64'd0);
        chk("mid_post_rdc", 64'(rdc_o), 64'd0);
        chk("mid_post_wrb", 64'(wrb_o), 64'd0);
        seen = 0;
        repeat (6) begin
            if (ready_o) seen++;
            @(negedge clk);
        end
        chk("mid_no_more_beats", 64'(seen), 64'd0);
        do_read(29'h00003FF, 1, 1'b0);
        if (rbeat.size() >= 1) chk("mid_kept_data", rbeat[0], 64'd2);

        // Zero-length burst is dropped
        addr = 29'h0000009; bcnt = 8'd0; be = 8'hFF; din = 64'hDEAD; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
        chk("zero_perr", 64'(perr_o), 64'd1);
        chk("zero_wrb", 64'(wrb_o), 64'd0);
        do_read(29'h0000009, 1, 1'b0);
        if (rbeat.size() >= 1) chk("zero_dropped_data", rbeat[0], 64'h0909090909090909);
        chk("zero_rdc", 64'(rdc_o), 64'd2);
        chk("zero_perr_sticky", 64'(perr_o), 64'd1);

        // Stalling instance against a byte-level scoreboard
        sel = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            v = {$urandom, $urandom};
            do_write(29'(i), 1, v, 8'hFF, 1'b0);
            sb[i] = v;
        end
        for (int i = 0; i < 200; i++) begin
            a = 29'($urandom_range(0, 13));
            n = int'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 0) begin
                v = {$urandom, $urandom};
                b = 8'($urandom_range(1, 255));
                do_write(a, n, v, b, 1'b0);
                for (int k = 0; k < n; k++) begin
                    for (int bb = 0; bb < 8; bb++) begin
                        if (b[bb]) sb[int'(a) + k][8*bb +: 8] = (v + 64'(k)) >> (8*bb);
                    end
                end
            end else begin
                do_read(a, n, 1'b0);
                chk("st_nbeats", 64'(rbeat.size()), 64'(n));
                for (int k = 0; k < n; k++) begin
                    if (k < rbeat.size()) chk("st_data", rbeat[k], sb[int'(a) + k]);
                end
            end
        end
        chk("st_busy_stall_seen", 64'(stall_seen), 64'd1);
        chk("st_beat_gap_seen", 64'(gap_seen), 64'd1);
        chk("st_perr", 64'(perr_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
